load_store_unit: RTL and testbench

Memory-stage load/store unit. It sits on the far end of the decoder's memory-control encodings: it consumes the 2-bit store-width code and the 3-bit load-type code and turns them into word-aligned bus transactions with byte enables. It sign- or zero-extends returned load data and stalls the pipeline while the data-memory handshake is in flight. It sits between the EX/MEM register and the data memory port.

---
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns store/load width codes into word-aligned
// bus transactions with byte enables, extends returned load data and stalls
// the pipeline while the data-memory handshake is outstanding.
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    input  logic [1:0]            store_type_i,
    input  logic [2:0]            load_type_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic                  misalign_o,
    output logic                  bus_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  st_q, uns_q, bus_err_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;

    // size code shared by stores and loads: 01 word, 10 half, 11 byte
    logic                  is_store, is_load, op_ok, misal, start, timeout;
    logic [1:0]            size;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wd, ext;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;

    // Decode the incoming op: kind, size, alignment and whether it launches
    always_comb begin
        is_store = (store_type_i != 2'b00);
        is_load  = 1'b0;
        case (load_type_i)
            3'b001, 3'b010, 3'b011, 3'b110, 3'b111: is_load = !is_store;
            default: is_load = 1'b0;
        endcase
        op_ok = is_store || is_load;
        size  = is_store ? store_type_i : load_type_i[1:0];
        misal = ((size == 2'b01) && (addr_i[1:0] != 2'b00)) ||
                ((size == 2'b10) && addr_i[0]);
        start = (state == S_IDLE) && req_valid_i && op_ok && !misal;
        timeout = (state == S_WAIT) && !mem_rvalid_i &&
                  (cnt == CNT_WIDTH'(TIMEOUT_CYCLES));
    end

    // Byte enables and lane-replicated write data from the latched op
    always_comb begin
        be = 4'b1111;
        wd = wdata_q;
        if (st_q) begin
            case (size_q)
                2'b10: begin
                    be = addr_q[1] ? 4'b1100 : 4'b0011;
                    wd = {2{wdata_q[15:0]}};
                end
                2'b11: begin
                    be = 4'b0001 << addr_q[1:0];
                    wd = {4{wdata_q[7:0]}};
                end
                default: ;
            endcase
        end
    end

    // Lane select and sign/zero extension of the returned word
    always_comb begin
        lane_b = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_q)
            2'b11:   ext = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b10:   ext = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: ext = mem_rdata_i;
        endcase
    end

    // Next-state logic; rvalid is only looked at in WAIT
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_REQ;
            S_REQ:   if (mem_ready_i) state_nxt = st_q ? S_IDLE : S_WAIT;
            S_WAIT:  if (mem_rvalid_i) state_nxt = S_RESP;
                     else if (timeout) state_nxt = S_IDLE;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Op latch, timeout counter, load result and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (start) begin
                st_q    <= is_store;
                uns_q   <= load_type_i[2];
                size_q  <= size;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            if ((state == S_REQ) && mem_ready_i)                   cnt <= '0;
            else if ((state == S_WAIT) && !mem_rvalid_i && !timeout) cnt <= cnt + 1'b1;
            if ((state == S_WAIT) && mem_rvalid_i) rdata_q <= ext;
            else if (timeout)                      rdata_q <= '0;
            bus_err_q <= timeout;
        end
    end

    // Outputs; the combinational ones are forced low while reset is held
    always_comb begin
        stall_o       = rst_n && (start || (state == S_REQ) || (state == S_WAIT));
        misalign_o    = rst_n && (state == S_IDLE) && req_valid_i && op_ok && misal;
        rdata_o       = rdata_q;
        rdata_valid_o = (state == S_RESP);
        bus_err_o     = bus_err_q;
        mem_req_o     = (state == S_REQ);
        mem_we_o      = (state == S_REQ) && st_q;
        mem_be_o      = (state == S_REQ) ? be : 4'b0000;
        mem_addr_o    = (state == S_REQ) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
        mem_wdata_o   = ((state == S_REQ) && st_q) ? wd : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random bench for load_store_unit with a byte-arithmetic model.
module tb_load_store_unit;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [1:0]  store_type;
    logic [2:0]  load_type;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid, misalign, bus_err;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] last_rdata = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .store_type_i(store_type),
        .load_type_i(load_type), .addr_i(addr), .wdata_i(wdata), .stall_o(stall),
        .rdata_o(rdata), .rdata_valid_o(rdata_valid), .misalign_o(misalign),
        .bus_err_o(bus_err), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // access size in bytes; 0 means no operation
    function automatic int op_size(input logic [1:0] st, input logic [2:0] lt);
        if (st == 2'd1) return 4;
        if (st == 2'd2) return 2;
        if (st == 2'd3) return 1;
        case (lt)
            3'd1:       return 4;
            3'd2, 3'd6: return 2;
            3'd3, 3'd7: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input int sz, input logic [31:0] a);
        int v;
        v = ((1 << sz) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] w);
        longint v;
        if (sz == 4) return w;
        if (sz == 2) v = longint'(w & 32'hFFFF) * 64'h0001_0001;
        else         v = longint'(w & 32'hFF) * 64'h0101_0101;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [31:0] a,
                                               input logic [31:0] rw);
        int sz;
        longint v;
        sz = op_size(2'd0, lt);
        v = longint'(rw) >> (8 * (a % 4));
        v = v & ((64'd1 << (8 * sz)) - 1);
        if (!(lt == 3'd6 || lt == 3'd7) && sz < 4 && v >= (64'd1 << (8 * sz - 1)))
            v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    // Run one op end to end; vd < 0 means memory never returns read data
    task automatic do_op(input logic [1:0] st, input logic [2:0] lt, input logic [31:0] a,
                         input logic [31:0] w, input int rd, input int vd, input logic [31:0] rw);
        int sz;
        int bad;
        logic [31:0] exp_r;
        sz = op_size(st, lt);
        @(posedge clk); #1;
        req_valid = 1'b1; store_type = st; load_type = lt; addr = a; wdata = w;
        @(negedge clk);
        if (sz == 0) begin
            check("noop_stall", {31'b0, stall}, 32'd0);
            check("noop_misal", {31'b0, misalign}, 32'd0);
            @(posedge clk); #1;
            check("noop_req", {31'b0, mem_req}, 32'd0);
            req_valid = 1'b0;
            return;
        end
        if ((a % sz) != 0) begin
            check("mis_pulse", {31'b0, misalign}, 32'd1);
            check("mis_stall", {31'b0, stall}, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("mis_noreq", {31'b0, mem_req}, 32'd0);
            req_valid = 1'b0;
            #1;
            check("mis_idle_stall", {31'b0, stall | misalign}, 32'd0);
            return;
        end
        check("idle_stall", {31'b0, stall}, 32'd1);
        check("idle_noreq", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i <= rd; i++) begin
            mem_ready = (i == rd);
            mem_rvalid = (i == rd);   // must be ignored while still in REQ
            mem_rdata = ~rw;
            @(negedge clk);
            if (mem_req !== 1'b1 || stall !== 1'b1 || mem_addr !== (a - (a % 4)) ||
                mem_we !== (st != 0)) bad++;
            if (st != 0 && (mem_be !== model_be(sz, a) || mem_wdata !== model_wdata(sz, w))) bad++;
            if (st == 0 && mem_be !== 4'b1111) bad++;
            @(posedge clk); #1;
        end
        check("req_phase", bad, 0);
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        if (st != 0) begin
            req_valid = 1'b0;
            @(negedge clk);
            check("st_done_stall", {31'b0, stall}, 32'd0);
            check("st_done_req", {31'b0, mem_req}, 32'd0);
            check("st_no_rvalid", {31'b0, rdata_valid}, 32'd0);
            check("st_rdata_hold", rdata, last_rdata);
            return;
        end
        bad = 0;
        if (vd < 0) begin
            for (int j = 0; j <= TO; j++) begin
                @(negedge clk);
                if (stall !== 1'b1 || bus_err !== 1'b0 || mem_req !== 1'b0) bad++;
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
            check("to_wait", bad, 0);
            @(negedge clk);
            check("to_buserr", {31'b0, bus_err}, 32'd1);
            check("to_rdata", rdata, 32'd0);
            check("to_stall", {31'b0, stall}, 32'd0);
            last_rdata = 32'd0;
            @(posedge clk); #1;
            @(negedge clk);
            check("to_pulse_end", {31'b0, bus_err}, 32'd0);
            return;
        end
        for (int j = 0; j <= vd; j++) begin
            mem_rvalid = (j == vd);
            mem_rdata = (j == vd) ? rw : $urandom;
            @(negedge clk);
            if (stall !== 1'b1 || mem_req !== 1'b0 || rdata_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("wait_phase", bad, 0);
        mem_rvalid = 1'b0; req_valid = 1'b0;
        exp_r = model_load(lt, a, rw);
        @(negedge clk);
        check("resp_valid", {31'b0, rdata_valid}, 32'd1);
        check("resp_stall", {31'b0, stall}, 32'd0);
        check("resp_data", rdata, exp_r);
        last_rdata = exp_r;
        @(posedge clk); #1;
        @(negedge clk);
        check("resp_one_cycle", {31'b0, rdata_valid}, 32'd0);
        check("rdata_hold", rdata, exp_r);
    endtask

    initial begin
        logic [2:0] ltab [8];
        ltab = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd7, 3'd0, 3'd4, 3'd5};
        rst_n = 1'b0; req_valid = 1'b0; store_type = 2'b00; load_type = 3'b000;
        addr = '0; wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", {31'b0, |{stall, rdata, rdata_valid, misalign, bus_err,
              mem_req, mem_we, mem_be, mem_addr, mem_wdata}}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // stores
        do_op(2'd1, 3'd0, 32'h100, 32'hDEADBEEF, 2, 0, 0);
        do_op(2'd3, 3'd1, 32'h103, 32'h000000A5, 0, 0, 0);
        do_op(2'd2, 3'd0, 32'h102, 32'h00001234, 1, 0, 0);
        // loads with extension
        do_op(2'd0, 3'd3, 32'h201, 32'h0, 0, 3, 32'h0000F000);
        do_op(2'd0, 3'd7, 32'h201, 32'h0, 0, 3, 32'h0000F000);
        do_op(2'd0, 3'd2, 32'h202, 32'h0, 1, 0, 32'h80010000);
        do_op(2'd0, 3'd1, 32'h204, 32'h0, 0, 1, 32'h89ABCDEF);
        // misalignment and no-op
        do_op(2'd0, 3'd1, 32'h206, 32'h0, 0, 0, 0);
        do_op(2'd0, 3'd2, 32'h203, 32'h0, 0, 0, 0);
        do_op(2'd3, 3'd0, 32'h203, 32'h11223344, 0, 0, 0);
        do_op(2'd0, 3'd4, 32'h200, 32'h0, 0, 0, 0);
        // read-data timeout
        do_op(2'd0, 3'd1, 32'h300, 32'h0, 0, -1, 0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] st;
            logic [2:0] lt;
            if ($urandom_range(0, 9) < 4) begin
                st = 2'($urandom_range(1, 3)); lt = 3'($urandom_range(0, 7));
            end else begin
                st = 2'd0; lt = ltab[$urandom_range(0, 7)];
            end
            do_op(st, lt, 32'h400 + $urandom_range(0, 63), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 4), $urandom);
        end

        // make rdata nonzero, then reset in the middle of a load's WAIT
        do_op(2'd0, 3'd1, 32'h500, 32'h0, 0, 0, 32'hCAFEF00D);
        @(posedge clk); #1;
        req_valid = 1'b1; store_type = 2'd0; load_type = 3'd1; addr = 32'h304;
        @(posedge clk); #1 mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        @(negedge clk);
        check("rst_pre_wait", {31'b0, stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {31'b0, |{stall, rdata, rdata_valid, misalign, bus_err,
              mem_req, mem_we, mem_be, mem_addr, mem_wdata}}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        check("late_rvalid_ign", {31'b0, rdata_valid}, 32'd0);
        check("late_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1 mem_rvalid = 1'b0;
        @(negedge clk);
        check("late_rvalid_ign2", {31'b0, rdata_valid}, 32'd0);
        check("late_rdata", rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
